spi_register_controller: RTL and testbench

Sequencer sitting behind `simple_spi_slave`: interprets the words it delivers as register-access transactions and drives a generic register bus. The first word of each chip-select frame is a command (direction and start address); subsequent words are data, with auto-incrementing address. It also supplies the slave's outgoing word: a status word during the command, then read data.

---
 rtl/spi_register_controller.sv | 137 +++++++++++++
 tb/tb_spi_register_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_register_controller.sv
// Register-access sequencer behind simple_spi_slave: the first word of each frame is a
// command (direction + start address), later words are data with auto-incrementing address.
module spi_register_controller #(
  parameter int              WIDTH       = 8,
  parameter int              ADDR_BITS   = 4,
  parameter logic [WIDTH-1:0] STATUS_WORD = 8'hA5
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     value_mosi,
  input  logic                 value_valid,
  input  logic                 cs_start,
  input  logic                 cs_stop,
  output logic [WIDTH-1:0]     value_miso,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [WIDTH-1:0]     reg_wdata,
  output logic                 reg_write,
  output logic                 reg_read,
  input  logic [WIDTH-1:0]     reg_rdata,
  output logic                 in_frame
);

  // ISSUE is the cycle reg_read is on the bus; read data only arrives the cycle after,
  // which is when FETCH captures it.
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ISSUE,
    FETCH,
    WDATA,
    RDATA
  } state_t;

  state_t                 state, state_n;
  logic [ADDR_BITS-1:0]   addr, addr_n;
  logic [WIDTH-1:0]       miso_n;
  logic [ADDR_BITS-1:0]   reg_addr_n;
  logic [WIDTH-1:0]       wdata_n;
  logic                   write_n;
  logic                   read_n;
  logic                   frame_n;
  logic [ADDR_BITS-1:0]   cmd_addr;

  assign cmd_addr = value_mosi[ADDR_BITS-1:0];

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      value_miso <= STATUS_WORD;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_write  <= 1'b0;
      reg_read   <= 1'b0;
      in_frame   <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      value_miso <= miso_n;
      reg_addr   <= reg_addr_n;
      reg_wdata  <= wdata_n;
      reg_write  <= write_n;
      reg_read   <= read_n;
      in_frame   <= frame_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    miso_n     = value_miso;
    reg_addr_n = reg_addr;
    wdata_n    = reg_wdata;
    write_n    = 1'b0;
    read_n     = 1'b0;
    frame_n    = in_frame;

    if (cs_start) begin
      // A start outside IDLE means the stop was missed: abandon the frame and await a command.
      state_n = CMD;
      frame_n = 1'b1;
      miso_n  = STATUS_WORD;
    end else begin
      case (state)
        IDLE: begin
          miso_n = STATUS_WORD;
        end
        CMD: begin
          if (value_valid) begin
            addr_n = cmd_addr;
            if (value_mosi[WIDTH-1]) begin
              state_n = WDATA;
            end else begin
              reg_addr_n = cmd_addr;
              read_n     = 1'b1;
              state_n    = ISSUE;
            end
          end
        end
        ISSUE: begin
          state_n = FETCH;
        end
        FETCH: begin
          miso_n  = reg_rdata;
          addr_n  = addr + 1'b1;
          state_n = RDATA;
        end
        WDATA: begin
          if (value_valid) begin
            reg_addr_n = addr;
            wdata_n    = value_mosi;
            write_n    = 1'b1;
            addr_n     = addr + 1'b1;
          end
        end
        RDATA: begin
          if (value_valid) begin
            reg_addr_n = addr;
            read_n     = 1'b1;
            state_n    = ISSUE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase

      // The word arriving with a stop is handled above first; a pending fetch is dropped here.
      if (cs_stop) begin
        state_n = IDLE;
        frame_n = 1'b0;
        miso_n  = STATUS_WORD;
      end
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed bench for spi_register_controller with a 16-entry register model that
// answers reg_read one cycle later.
module tb_spi_register_controller;

  logic       system_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value_mosi = 8'h00;
  logic       value_valid = 1'b0;
  logic       cs_start = 1'b0;
  logic       cs_stop = 1'b0;
  logic [7:0] value_miso;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata = 8'h00;
  logic       in_frame;

  logic [7:0] mem [16];
  int vectors = 0;
  int miscompares = 0;

  spi_register_controller #(
    .WIDTH(8),
    .ADDR_BITS(4),
    .STATUS_WORD(8'hA5)
  ) dut (
    .system_clk (system_clk),
    .rst        (rst),
    .value_mosi (value_mosi),
    .value_valid(value_valid),
    .cs_start   (cs_start),
    .cs_stop    (cs_stop),
    .value_miso (value_miso),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_rdata  (reg_rdata),
    .in_frame   (in_frame)
  );

  always #5 system_clk = ~system_clk;

  // Register model: read data appears the cycle after the strobe.
  always @(posedge system_clk) begin
    if (reg_read) reg_rdata <= mem[reg_addr];
    if (reg_write) mem[reg_addr] <= reg_wdata;
  end

  // Drive one cycle of inputs, let the DUT take the edge, then clear the strobes.
  task automatic applyStimulus(input logic valid, input logic [7:0] mosi,
                               input logic start, input logic stop);
    value_valid = valid;
    value_mosi  = mosi;
    cs_start    = start;
    cs_stop     = stop;
    @(posedge system_clk);
    #1;
    value_valid = 1'b0;
    cs_start    = 1'b0;
    cs_stop     = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset asserted in the middle of a write frame
    rst = 1'b1;
    idle();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
    rst = 1'b1;
    idle();
    idle();
    checkOutput("rst_miso", 32'(value_miso), 32'hA5);
    checkOutput("rst_addr", 32'(reg_addr), 32'h0);
    checkOutput("rst_wdata", 32'(reg_wdata), 32'h00);
    checkOutput("rst_write", 32'(reg_write), 32'h0);
    checkOutput("rst_read", 32'(reg_read), 32'h0);
    checkOutput("rst_frame", 32'(in_frame), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("post_rst_write", 32'(reg_write), 32'h0);
    checkOutput("post_rst_read", 32'(reg_read), 32'h0);
    checkOutput("post_rst_miso", 32'(value_miso), 32'hA5);

    // Write burst starting at address 3
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wr_frame_up", 32'(in_frame), 32'h1);
    applyStimulus(1'b1, 8'h83, 1'b0, 1'b0);
    checkOutput("wr_cmd_nowrite", 32'(reg_write), 32'h0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("wr0_strobe", 32'(reg_write), 32'h1);
    checkOutput("wr0_addr", 32'(reg_addr), 32'h3);
    checkOutput("wr0_data", 32'(reg_wdata), 32'h11);
    checkOutput("wr0_miso", 32'(value_miso), 32'hA5);
    idle();
    checkOutput("wr0_strobe_drop", 32'(reg_write), 32'h0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("wr1_strobe", 32'(reg_write), 32'h1);
    checkOutput("wr1_addr", 32'(reg_addr), 32'h4);
    checkOutput("wr1_data", 32'(reg_wdata), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("wr_frame_down", 32'(in_frame), 32'h0);
    checkOutput("wr_miso_end", 32'(value_miso), 32'hA5);

    // Read burst from address 7
    mem[7] = 8'h5A;
    mem[8] = 8'hC3;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
    checkOutput("rd0_strobe", 32'(reg_read), 32'h1);
    checkOutput("rd0_addr", 32'(reg_addr), 32'h7);
    idle();
    checkOutput("rd0_strobe_drop", 32'(reg_read), 32'h0);
    checkOutput("rd0_miso_early", 32'(value_miso), 32'hA5);
    idle();
    checkOutput("rd0_miso", 32'(value_miso), 32'h5A);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("rd1_strobe", 32'(reg_read), 32'h1);
    checkOutput("rd1_addr", 32'(reg_addr), 32'h8);
    idle();
    idle();
    checkOutput("rd1_miso", 32'(value_miso), 32'hC3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rd_miso_end", 32'(value_miso), 32'hA5);
    checkOutput("rd_frame_down", 32'(in_frame), 32'h0);

    // Address wrap 15 -> 0
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h8F, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("wrap0_strobe", 32'(reg_write), 32'h1);
    checkOutput("wrap0_addr", 32'(reg_addr), 32'hF);
    checkOutput("wrap0_data", 32'(reg_wdata), 32'hAA);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
    checkOutput("wrap1_strobe", 32'(reg_write), 32'h1);
    checkOutput("wrap1_addr", 32'(reg_addr), 32'h0);
    checkOutput("wrap1_data", 32'(reg_wdata), 32'hBB);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Stop during the fetch cycle: the fetched word must never reach value_miso
    mem[7] = 8'h5A;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
    checkOutput("abort_read_strobe", 32'(reg_read), 32'h1);
    idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("abort_miso", 32'(value_miso), 32'hA5);
    checkOutput("abort_frame", 32'(in_frame), 32'h0);
    idle();
    checkOutput("abort_miso_later", 32'(value_miso), 32'hA5);

    // Data word together with stop: write commits, frame closes
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h85, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("simul_strobe", 32'(reg_write), 32'h1);
    checkOutput("simul_addr", 32'(reg_addr), 32'h5);
    checkOutput("simul_data", 32'(reg_wdata), 32'h77);
    checkOutput("simul_frame", 32'(in_frame), 32'h0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("simul_idle_ignore", 32'(reg_write), 32'h0);

    // Missed stop: a second start mid-write turns the next word into a command
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("restart_frame", 32'(in_frame), 32'h1);
    checkOutput("restart_nowrite", 32'(reg_write), 32'h0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    checkOutput("restart_read", 32'(reg_read), 32'h1);
    checkOutput("restart_addr", 32'(reg_addr), 32'h2);
    checkOutput("restart_write", 32'(reg_write), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("restart_end_write", 32'(reg_write), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
